elc3_control_unit: RTL and testbench

- Moore FSM that sequences the eLC-3 datapath through fetch, decode and execute for the LC-3 ISA.
- Consumes decoded instruction fields, BEN and memory-ready.
- Drives every datapath load, gate, mux-select and ALU-function signal, plus memory enable and read/write.
- Sits beside the datapath inside the CPU top level. It adds no datapath registers.

---
 rtl/elc3_pkg.sv | 91 +++++++++
 rtl/elc3_control_unit_if.sv | 38 +++
 rtl/elc3_ctrl_decode.sv | 126 ++++++++++++
 rtl/elc3_control_unit.sv | 106 ++++++++++
 tb/tb_elc3_control_unit.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/elc3_pkg.sv
`default_nettype none
// ============================================================================
// Module   : elc3_pkg
// Brief    : Shared encodings for the eLC-3 control unit (opcodes, states,
//            mux selects, ALU functions, control word).
// Revision : 1.0
// ============================================================================
package elc3_pkg;

    typedef enum logic [3:0] {
        OP_BR   = 4'b0000,
        OP_ADD  = 4'b0001,
        OP_LD   = 4'b0010,
        OP_ST   = 4'b0011,
        OP_JSR  = 4'b0100,
        OP_AND  = 4'b0101,
        OP_LDR  = 4'b0110,
        OP_STR  = 4'b0111,
        OP_RTI  = 4'b1000,
        OP_NOT  = 4'b1001,
        OP_LDI  = 4'b1010,
        OP_STI  = 4'b1011,
        OP_JMP  = 4'b1100,
        OP_RES  = 4'b1101,
        OP_LEA  = 4'b1110,
        OP_TRAP = 4'b1111
    } opcode_e;

    typedef enum logic [5:0] {
        S_HALT, S_FETCH1, S_FETCH2, S_FETCH3, S_DECODE,
        S_ADD_R, S_ADD_I, S_AND_R, S_AND_I, S_NOT_R, S_NOT_I,
        S_BR_TAKEN, S_JMP, S_JSR1, S_JSR2_OFF, S_JSR2_REG,
        S_LD_ADDR, S_LDR_ADDR, S_LDI_ADDR, S_LDI_READ, S_LDI_IND,
        S_LD_READ, S_LD_FINAL,
        S_ST_ADDR, S_STR_ADDR, S_STI_ADDR, S_STI_READ, S_STI_IND,
        S_ST_DATA, S_ST_WRITE,
        S_LEA, S_TRAP1, S_TRAP2, S_TRAP3, S_TRAP4,
        S_PAUSE1, S_PAUSE2
    } state_e;

    localparam logic       ADDR1_PC     = 1'b0;
    localparam logic       ADDR1_SR1    = 1'b1;
    localparam logic [1:0] ADDR2_ZERO   = 2'd0;
    localparam logic [1:0] ADDR2_SEXT6  = 2'd1;
    localparam logic [1:0] ADDR2_SEXT9  = 2'd2;
    localparam logic [1:0] ADDR2_SEXT11 = 2'd3;
    localparam logic [1:0] PC_PLUS1     = 2'd0;
    localparam logic [1:0] PC_BUS       = 2'd1;
    localparam logic [1:0] PC_ADDR      = 2'd2;
    localparam logic [1:0] DR_IR119     = 2'd0;
    localparam logic [1:0] DR_R7        = 2'd1;
    localparam logic [1:0] DR_R6        = 2'd2;
    localparam logic [1:0] SR1_IR119    = 2'd0;
    localparam logic [1:0] SR1_IR86     = 2'd1;
    localparam logic [1:0] SR1_R6       = 2'd2;
    localparam logic [1:0] SR2_REG      = 2'd0;
    localparam logic [1:0] SR2_SEXT5    = 2'd1;
    localparam logic [1:0] MARMUX_ZEXT8 = 2'd0;
    localparam logic [1:0] MARMUX_ADDR  = 2'd1;

    localparam logic [1:0] ALUK_ADD   = 2'd0;
    localparam logic [1:0] ALUK_AND   = 2'd1;
    localparam logic [1:0] ALUK_NOT   = 2'd2;
    localparam logic [1:0] ALUK_PASSA = 2'd3;

    typedef struct packed {
        logic       ld_mar;
        logic       ld_mdr;
        logic       ld_ir;
        logic       ld_ben;
        logic       ld_reg;
        logic       ld_cc;
        logic       ld_pc;
        logic       gate_pc;
        logic       gate_mdr;
        logic       gate_alu;
        logic       gate_marmux;
        logic       addr1mux;
        logic [1:0] addr2mux;
        logic [1:0] pcmux;
        logic [1:0] drmux;
        logic [1:0] sr1mux;
        logic [1:0] sr2mux;
        logic [1:0] marmux;
        logic [1:0] aluk;
        logic       mio_en;
        logic       r_w;
    } ctrl_t;

endpackage
`default_nettype wire

// File: rtl/elc3_control_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : elc3_control_unit_if
// Brief    : Status inputs and control outputs between control unit and datapath.
// Revision : 1.0
// ============================================================================
interface elc3_control_unit_if;
    logic       Run;
    logic       Continue;
    logic [3:0] Opcode;
    logic       IR_5;
    logic       IR_11;
    logic       BEN;
    logic       R;

    logic       LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_REG, LD_CC, LD_PC;
    logic       GatePC, GateMDR, GateALU, GateMARMUX;
    logic       ADDR1MUX;
    logic [1:0] ADDR2MUX, PCMUX, DRMUX, SR1MUX, SR2MUX, MARMUX, ALUK;
    logic       MIO_EN, R_W;

    modport master (
        input  Run, Continue, Opcode, IR_5, IR_11, BEN, R,
        output LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_REG, LD_CC, LD_PC,
        output GatePC, GateMDR, GateALU, GateMARMUX,
        output ADDR1MUX, ADDR2MUX, PCMUX, DRMUX, SR1MUX, SR2MUX, MARMUX, ALUK,
        output MIO_EN, R_W
    );

    modport slave (
        output Run, Continue, Opcode, IR_5, IR_11, BEN, R,
        input  LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_REG, LD_CC, LD_PC,
        input  GatePC, GateMDR, GateALU, GateMARMUX,
        input  ADDR1MUX, ADDR2MUX, PCMUX, DRMUX, SR1MUX, SR2MUX, MARMUX, ALUK,
        input  MIO_EN, R_W
    );
endinterface
`default_nettype wire

// File: rtl/elc3_ctrl_decode.sv
`default_nettype none
// ============================================================================
// Module   : elc3_ctrl_decode
// Brief    : Combinational state-to-control-word table for the eLC-3 FSM.
// Revision : 1.0
// ============================================================================
module elc3_ctrl_decode
    import elc3_pkg::*;
(
    input  state_e i_state,
    output ctrl_t  o_cw
);

    always_comb begin
        o_cw = '0;
        case (i_state)
            S_FETCH1: begin
                o_cw.addr1mux    = ADDR1_PC;
                o_cw.addr2mux    = ADDR2_ZERO;
                o_cw.marmux      = MARMUX_ADDR;
                o_cw.gate_marmux = 1'b1;
                o_cw.ld_mar      = 1'b1;
                o_cw.pcmux       = PC_PLUS1;
                o_cw.ld_pc       = 1'b1;
            end
            S_FETCH2, S_LD_READ, S_LDI_READ, S_STI_READ, S_TRAP3: begin
                o_cw.mio_en = 1'b1;
                o_cw.ld_mdr = 1'b1;
            end
            S_FETCH3: begin
                o_cw.gate_mdr = 1'b1;
                o_cw.ld_ir    = 1'b1;
            end
            S_DECODE: o_cw.ld_ben = 1'b1;
            S_ADD_R, S_ADD_I, S_AND_R, S_AND_I, S_NOT_R, S_NOT_I: begin
                o_cw.sr1mux   = SR1_IR86;
                o_cw.sr2mux   = (i_state inside {S_ADD_I, S_AND_I, S_NOT_I}) ? SR2_SEXT5 : SR2_REG;
                o_cw.aluk     = (i_state inside {S_AND_R, S_AND_I}) ? ALUK_AND :
                                (i_state inside {S_NOT_R, S_NOT_I}) ? ALUK_NOT : ALUK_ADD;
                o_cw.gate_alu = 1'b1;
                o_cw.drmux    = DR_IR119;
                o_cw.ld_reg   = 1'b1;
                o_cw.ld_cc    = 1'b1;
            end
            S_BR_TAKEN, S_JSR2_OFF: begin
                o_cw.addr1mux = ADDR1_PC;
                o_cw.addr2mux = (i_state == S_BR_TAKEN) ? ADDR2_SEXT9 : ADDR2_SEXT11;
                o_cw.pcmux    = PC_ADDR;
                o_cw.ld_pc    = 1'b1;
            end
            S_JMP, S_JSR2_REG: begin
                o_cw.sr1mux   = SR1_IR86;
                o_cw.addr1mux = ADDR1_SR1;
                o_cw.addr2mux = ADDR2_ZERO;
                o_cw.pcmux    = PC_ADDR;
                o_cw.ld_pc    = 1'b1;
            end
            // PC reaches R7 over the bus; PCMUX points at ADDR so the bus never feeds itself
            S_JSR1, S_TRAP2: begin
                o_cw.addr1mux = ADDR1_PC;
                o_cw.addr2mux = ADDR2_ZERO;
                o_cw.pcmux    = PC_ADDR;
                o_cw.gate_pc  = 1'b1;
                o_cw.drmux    = DR_R7;
                o_cw.ld_reg   = 1'b1;
            end
            S_LD_ADDR, S_LDI_ADDR, S_ST_ADDR, S_STI_ADDR: begin
                o_cw.addr1mux    = ADDR1_PC;
                o_cw.addr2mux    = ADDR2_SEXT9;
                o_cw.marmux      = MARMUX_ADDR;
                o_cw.gate_marmux = 1'b1;
                o_cw.ld_mar      = 1'b1;
            end
            S_LDR_ADDR, S_STR_ADDR: begin
                o_cw.sr1mux      = SR1_IR86;
                o_cw.addr1mux    = ADDR1_SR1;
                o_cw.addr2mux    = ADDR2_SEXT6;
                o_cw.marmux      = MARMUX_ADDR;
                o_cw.gate_marmux = 1'b1;
                o_cw.ld_mar      = 1'b1;
            end
            S_LDI_IND, S_STI_IND: begin
                o_cw.gate_mdr = 1'b1;
                o_cw.ld_mar   = 1'b1;
            end
            S_LD_FINAL: begin
                o_cw.gate_mdr = 1'b1;
                o_cw.drmux    = DR_IR119;
                o_cw.ld_reg   = 1'b1;
                o_cw.ld_cc    = 1'b1;
            end
            S_ST_DATA: begin
                o_cw.sr1mux   = SR1_IR119;
                o_cw.aluk     = ALUK_PASSA;
                o_cw.gate_alu = 1'b1;
                o_cw.ld_mdr   = 1'b1;
            end
            S_ST_WRITE: begin
                o_cw.mio_en = 1'b1;
                o_cw.r_w    = 1'b1;
            end
            S_LEA: begin
                o_cw.addr1mux    = ADDR1_PC;
                o_cw.addr2mux    = ADDR2_SEXT9;
                o_cw.marmux      = MARMUX_ADDR;
                o_cw.gate_marmux = 1'b1;
                o_cw.drmux       = DR_IR119;
                o_cw.ld_reg      = 1'b1;
                o_cw.ld_cc       = 1'b1;
            end
            S_TRAP1: begin
                o_cw.marmux      = MARMUX_ZEXT8;
                o_cw.gate_marmux = 1'b1;
                o_cw.ld_mar      = 1'b1;
            end
            S_TRAP4: begin
                o_cw.gate_mdr = 1'b1;
                o_cw.pcmux    = PC_BUS;
                o_cw.ld_pc    = 1'b1;
            end
            default: o_cw = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/elc3_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : elc3_control_unit
// Brief    : Moore FSM sequencing the eLC-3 datapath through fetch/decode/execute.
// Revision : 1.0
// ============================================================================
module elc3_control_unit
    import elc3_pkg::*;
(
    input  logic               Clk,
    input  logic               Reset,
    elc3_control_unit_if.master bus
);

    state_e  r_state;
    state_e  w_next;
    ctrl_t   w_cw;
    opcode_e w_opcode;

    assign w_opcode = opcode_e'(bus.Opcode);

    always_ff @(posedge Clk) begin
        if (Reset) r_state <= S_HALT;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_HALT:   if (bus.Run) w_next = S_FETCH1;
            S_FETCH1: w_next = S_FETCH2;
            S_FETCH2: if (bus.R) w_next = S_FETCH3;
            S_FETCH3: w_next = S_DECODE;
            S_DECODE: begin
                case (w_opcode)
                    OP_ADD:  w_next = bus.IR_5 ? S_ADD_I : S_ADD_R;
                    OP_AND:  w_next = bus.IR_5 ? S_AND_I : S_AND_R;
                    OP_NOT:  w_next = bus.IR_5 ? S_NOT_I : S_NOT_R;
                    OP_BR:   w_next = bus.BEN ? S_BR_TAKEN : S_FETCH1;
                    OP_JMP:  w_next = S_JMP;
                    OP_JSR:  w_next = S_JSR1;
                    OP_LD:   w_next = S_LD_ADDR;
                    OP_LDR:  w_next = S_LDR_ADDR;
                    OP_LDI:  w_next = S_LDI_ADDR;
                    OP_ST:   w_next = S_ST_ADDR;
                    OP_STR:  w_next = S_STR_ADDR;
                    OP_STI:  w_next = S_STI_ADDR;
                    OP_LEA:  w_next = S_LEA;
                    OP_TRAP: w_next = S_TRAP1;
                    OP_RTI, OP_RES: w_next = S_PAUSE1;
                endcase
            end
            S_ADD_R, S_ADD_I, S_AND_R, S_AND_I, S_NOT_R, S_NOT_I,
            S_BR_TAKEN, S_JMP, S_JSR2_OFF, S_JSR2_REG,
            S_LD_FINAL, S_LEA, S_TRAP4:  w_next = S_FETCH1;
            // Mode bit picked after the link write, so JSRR R7 follows the new R7
            S_JSR1:     w_next = bus.IR_11 ? S_JSR2_OFF : S_JSR2_REG;
            S_LD_ADDR, S_LDR_ADDR:      w_next = S_LD_READ;
            S_LDI_ADDR: w_next = S_LDI_READ;
            S_LDI_READ: if (bus.R) w_next = S_LDI_IND;
            S_LDI_IND:  w_next = S_LD_READ;
            S_LD_READ:  if (bus.R) w_next = S_LD_FINAL;
            S_ST_ADDR, S_STR_ADDR:      w_next = S_ST_DATA;
            S_STI_ADDR: w_next = S_STI_READ;
            S_STI_READ: if (bus.R) w_next = S_STI_IND;
            S_STI_IND:  w_next = S_ST_DATA;
            S_ST_DATA:  w_next = S_ST_WRITE;
            S_ST_WRITE: if (bus.R) w_next = S_FETCH1;
            S_TRAP1:    w_next = S_TRAP2;
            S_TRAP2:    w_next = S_TRAP3;
            S_TRAP3:    if (bus.R) w_next = S_TRAP4;
            S_PAUSE1:   if (bus.Continue) w_next = S_PAUSE2;
            S_PAUSE2:   if (!bus.Continue) w_next = S_FETCH1;
            default:    w_next = S_HALT;
        endcase
    end

    elc3_ctrl_decode u_decode (
        .i_state (r_state),
        .o_cw    (w_cw)
    );

    assign bus.LD_MAR     = w_cw.ld_mar;
    assign bus.LD_MDR     = w_cw.ld_mdr;
    assign bus.LD_IR      = w_cw.ld_ir;
    assign bus.LD_BEN     = w_cw.ld_ben;
    assign bus.LD_REG     = w_cw.ld_reg;
    assign bus.LD_CC      = w_cw.ld_cc;
    assign bus.LD_PC      = w_cw.ld_pc;
    assign bus.GatePC     = w_cw.gate_pc;
    assign bus.GateMDR    = w_cw.gate_mdr;
    assign bus.GateALU    = w_cw.gate_alu;
    assign bus.GateMARMUX = w_cw.gate_marmux;
    assign bus.ADDR1MUX   = w_cw.addr1mux;
    assign bus.ADDR2MUX   = w_cw.addr2mux;
    assign bus.PCMUX      = w_cw.pcmux;
    assign bus.DRMUX      = w_cw.drmux;
    assign bus.SR1MUX     = w_cw.sr1mux;
    assign bus.SR2MUX     = w_cw.sr2mux;
    assign bus.MARMUX     = w_cw.marmux;
    assign bus.ALUK       = w_cw.aluk;
    assign bus.MIO_EN     = w_cw.mio_en;
    assign bus.R_W        = w_cw.r_w;

endmodule
`default_nettype wire

// File: tb/tb_elc3_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_elc3_control_unit
// Brief    : Directed self-checking bench for elc3_control_unit control words.
// Revision : 1.0
// ============================================================================
module tb_elc3_control_unit;

    // Control word layout used for comparison:
    // 27 LD_MAR 26 LD_MDR 25 LD_IR 24 LD_BEN 23 LD_REG 22 LD_CC 21 LD_PC
    // 20 GatePC 19 GateMDR 18 GateALU 17 GateMARMUX 16 ADDR1MUX
    // 15:14 ADDR2MUX 13:12 PCMUX 11:10 DRMUX 9:8 SR1MUX 7:6 SR2MUX
    // 5:4 MARMUX 3:2 ALUK 1 MIO_EN 0 R_W
    localparam logic [27:0] B_LD_MAR = 28'd1 << 27;
    localparam logic [27:0] B_LD_MDR = 28'd1 << 26;
    localparam logic [27:0] B_LD_IR  = 28'd1 << 25;
    localparam logic [27:0] B_LD_BEN = 28'd1 << 24;
    localparam logic [27:0] B_LD_REG = 28'd1 << 23;
    localparam logic [27:0] B_LD_CC  = 28'd1 << 22;
    localparam logic [27:0] B_LD_PC  = 28'd1 << 21;
    localparam logic [27:0] B_GPC    = 28'd1 << 20;
    localparam logic [27:0] B_GMDR   = 28'd1 << 19;
    localparam logic [27:0] B_GALU   = 28'd1 << 18;
    localparam logic [27:0] B_GMM    = 28'd1 << 17;
    localparam logic [27:0] B_A1     = 28'd1 << 16;
    localparam logic [27:0] B_MIO    = 28'd1 << 1;
    localparam logic [27:0] B_RW     = 28'd1;

    localparam logic [27:0] W_ZERO     = 28'd0;
    localparam logic [27:0] W_FETCH1   = B_LD_MAR | B_LD_PC | B_GMM | (28'd1 << 4);
    localparam logic [27:0] W_READ     = B_LD_MDR | B_MIO;
    localparam logic [27:0] W_FETCH3   = B_GMDR | B_LD_IR;
    localparam logic [27:0] W_DECODE   = B_LD_BEN;
    localparam logic [27:0] W_ADD_I    = B_LD_REG | B_LD_CC | B_GALU | (28'd1 << 8) | (28'd1 << 6);
    localparam logic [27:0] W_AND_R    = B_LD_REG | B_LD_CC | B_GALU | (28'd1 << 8) | (28'd1 << 2);
    localparam logic [27:0] W_BR       = B_LD_PC | (28'd2 << 14) | (28'd2 << 12);
    localparam logic [27:0] W_MAR_PC9  = B_LD_MAR | B_GMM | (28'd2 << 14) | (28'd1 << 4);
    localparam logic [27:0] W_IND      = B_GMDR | B_LD_MAR;
    localparam logic [27:0] W_ST_DATA  = B_LD_MDR | B_GALU | (28'd3 << 2);
    localparam logic [27:0] W_ST_WRITE = B_MIO | B_RW;
    localparam logic [27:0] W_TRAP1    = B_LD_MAR | B_GMM;
    localparam logic [27:0] W_LINK     = B_LD_REG | B_GPC | (28'd1 << 10) | (28'd2 << 12);
    localparam logic [27:0] W_TRAP4    = B_GMDR | B_LD_PC | (28'd1 << 12);
    localparam logic [27:0] W_JSRR     = B_LD_PC | B_A1 | (28'd1 << 8) | (28'd2 << 12);

    logic Clk;
    logic Reset;
    int   checks;
    int   failures;

    elc3_control_unit_if bus ();

    elc3_control_unit dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    logic [27:0] obs;
    assign obs = {bus.LD_MAR, bus.LD_MDR, bus.LD_IR, bus.LD_BEN, bus.LD_REG, bus.LD_CC,
                  bus.LD_PC, bus.GatePC, bus.GateMDR, bus.GateALU, bus.GateMARMUX,
                  bus.ADDR1MUX, bus.ADDR2MUX, bus.PCMUX, bus.DRMUX, bus.SR1MUX,
                  bus.SR2MUX, bus.MARMUX, bus.ALUK, bus.MIO_EN, bus.R_W};

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [27:0] got, input logic [27:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %07h expected %07h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Entered with FETCH1 as the current state and R=1; leaves DECODE current
    task automatic fetch(input string tag);
        check({tag, "_fetch1"}, obs, W_FETCH1);
        step();
        check({tag, "_fetch2"}, obs, W_READ);
        step();
        check({tag, "_fetch3"}, obs, W_FETCH3);
        step();
        check({tag, "_decode"}, obs, W_DECODE);
    endtask

    // Memory state held by R=0 for three cycles, completes on the fourth
    task automatic mem_access(input string tag, input logic [27:0] word);
        for (int i = 0; i < 4; i++) begin
            bus.R = (i == 3);
            check($sformatf("%s_c%0d", tag, i), obs, word);
            step();
        end
        bus.R = 1'b0;
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        Reset         = 1'b1;
        bus.Run       = 1'b0;
        bus.Continue  = 1'b0;
        bus.Opcode    = 4'b0000;
        bus.IR_5      = 1'b0;
        bus.IR_11     = 1'b0;
        bus.BEN       = 1'b0;
        bus.R         = 1'b0;
        step();
        step();
        check("reset_halt", obs, W_ZERO);

        // Reset lands mid-read with R=0
        Reset   = 1'b0;
        bus.Run = 1'b1;
        step();
        check("run_fetch1", obs, W_FETCH1);
        step();
        check("stall_fetch2_a", obs, W_READ);
        step();
        check("stall_fetch2_b", obs, W_READ);
        Reset = 1'b1;
        step();
        check("reset_abort", obs, W_ZERO);
        Reset = 1'b0;

        // ADD immediate
        bus.R      = 1'b1;
        bus.Opcode = 4'b0001;
        bus.IR_5   = 1'b1;
        step();
        bus.Run = 1'b0;
        fetch("add");
        step();
        check("add_exec", obs, W_ADD_I);
        step();

        // AND register mode
        bus.Opcode = 4'b0101;
        bus.IR_5   = 1'b0;
        fetch("and");
        step();
        check("and_exec", obs, W_AND_R);
        step();

        // BR not taken then taken
        bus.Opcode = 4'b0000;
        bus.BEN    = 1'b0;
        fetch("brn");
        step();
        check("br_not_taken", obs, W_FETCH1);
        bus.BEN = 1'b1;
        fetch("brt");
        step();
        check("br_taken", obs, W_BR);
        step();

        // STI with three wait cycles per access
        bus.Opcode = 4'b1011;
        fetch("sti");
        step();
        check("sti_addr", obs, W_MAR_PC9);
        bus.R = 1'b0;
        step();
        mem_access("sti_read", W_READ);
        check("sti_ind", obs, W_IND);
        step();
        check("sti_data", obs, W_ST_DATA);
        step();
        mem_access("sti_write", W_ST_WRITE);
        check("sti_done", obs, W_FETCH1);
        bus.R = 1'b1;

        // TRAP
        bus.Opcode = 4'b1111;
        fetch("trap");
        step();
        check("trap1", obs, W_TRAP1);
        step();
        check("trap2", obs, W_LINK);
        step();
        check("trap3", obs, W_READ);
        step();
        check("trap4", obs, W_TRAP4);
        step();

        // JSRR
        bus.Opcode = 4'b0100;
        bus.IR_11  = 1'b0;
        fetch("jsrr");
        step();
        check("jsrr_link", obs, W_LINK);
        step();
        check("jsrr_jump", obs, W_JSRR);
        step();

        // Reserved opcode pauses until a full Continue handshake
        bus.Opcode = 4'b1101;
        fetch("pause");
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("pause_wait%0d", i), obs, W_ZERO);
        end
        step();
        for (int i = 0; i < 5; i++) begin
            bus.Continue = 1'b1;
            check($sformatf("pause_hold%0d", i), obs, W_ZERO);
            step();
        end
        bus.Continue = 1'b0;
        check("pause_release", obs, W_ZERO);
        step();
        check("pause_resume", obs, W_FETCH1);
        step();
        check("pause_fetch2", obs, W_READ);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
